uart_tx: RTL and testbench

- 8N1 UART serial transmitter. Paced by the 16x-oversampling tick from the baud-rate generator: one-cycle pulse every 326 clk, i.e. 9600 baud at 50 MHz.
- Accepts a byte on a start strobe from the processor-side logic, shifts it out LSB first on `tx`, then reports completion.
- Pairs with the receiver on the same tick.

---
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_tx.sv | 154 +++++++++++++++
 tb/tb_uart_tx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - processor-side handshake and serial line bundle for uart_tx
// Optional macro UART_TX_PARITY_EN adds the parity_odd request bit.
interface uart_tx_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
`ifdef UART_TX_PARITY_EN
  logic            parity_odd;
`endif
  logic            tx;
  logic            tx_busy;
  logic            tx_done_tick;

`ifdef UART_TX_PARITY_EN
  modport master (output tx_start, din, parity_odd, input tx, tx_busy, tx_done_tick);
  modport slave  (input tx_start, din, parity_odd, output tx, tx_busy, tx_done_tick);
`else
  modport master (output tx_start, din, input tx, tx_busy, tx_done_tick);
  modport slave  (input tx_start, din, output tx, tx_busy, tx_done_tick);
`endif
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter paced by a 16x oversampling tick
// Optional macro UART_TX_PARITY_EN inserts a parity bit (8E1, or odd via parity_odd).
module uart_tx #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     s_tick,
  uart_tx_if.slave bus
);
  localparam int BW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [4:0]    OS_LAST  = 5'(OVERSAMPLE - 1);
  localparam logic [4:0]    SB_LAST  = 5'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [4:0]      tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        // a tick coinciding with acceptance is deliberately not counted
        if (bus.tx_start) begin
          shreg_d = bus.din;
          tick_d  = '0;
          busy_d  = 1'b1;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          par_d   = (^bus.din) ^ bus.parity_odd;
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = DATA;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (tick_q == OS_LAST) begin
            tick_d  = '0;
            state_d = STOP;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (tick_q == SB_LAST) begin
            tick_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            tick_d = tick_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // line level follows the next state so tx stays a clean register
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_busy      = busy_q;
  assign bus.tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx (fast 4-clk tick and real 326-clk tick)
`timescale 1ns/1ps
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FLEN_MIN   = 60 + 64 * (9 + PBITS) - 4 + 4;
  localparam int FLEN_MAX   = 64 + 64 * (9 + PBITS);
  localparam int STOP_B_EXP = (16 * PBITS + 32) * 326;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic tick_a = 1'b0;
  logic tick_b = 1'b0;
  int   div_a = 0;
  int   div_b = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  int   edge_t[$];
  int   done_t[$];
  logic tx_prev_a = 1'b1;

  uart_tx_if #(.DBIT(8)) ifa ();
  uart_tx_if #(.DBIT(8)) ifb ();

  uart_tx #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .s_tick(tick_a), .bus(ifa)
  );
  uart_tx #(.DBIT(8), .OVERSAMPLE(16), .SB_TICK(32)) dut_b (
    .clk(clk), .reset_n(reset_n), .s_tick(tick_b), .bus(ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    tick_a = (div_a == 3);
    div_a  = (div_a == 3) ? 0 : div_a + 1;
    tick_b = (div_b == 325);
    div_b  = (div_b == 325) ? 0 : div_b + 1;
  end

  always @(negedge clk) begin
    if (ifa.tx !== tx_prev_a) begin
      edge_t.push_back(cyc);
      tx_prev_a = ifa.tx;
    end
    if (ifa.tx_done_tick === 1'b1) done_t.push_back(cyc);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [7:0] b);
    @(posedge clk); #1;
    ifa.din = b;
    ifa.tx_start = 1'b1;
    @(posedge clk); #1;
    ifa.tx_start = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    @(posedge clk); #1;
    ifb.din = b;
    ifb.tx_start = 1'b1;
    @(posedge clk); #1;
    ifb.tx_start = 1'b0;
  endtask

  task automatic recv_a(output logic [7:0] data, output logic par, output logic stop_bit,
                        output logic busy_ok, output int flen);
    int t0;
    int n;
    data = '0; par = 1'b0; stop_bit = 1'b0; busy_ok = 1'b1; flen = 0;
    @(negedge clk);
    n = 0;
    while (ifa.tx !== 1'b0 && n < 2000) begin @(negedge clk); n++; end
    check_eq("rx_start_seen", ifa.tx, 1'b0);
    if (ifa.tx !== 1'b0) return;
    t0 = cyc;
    repeat (96) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      data[i] = ifa.tx;
      if (ifa.tx_busy !== 1'b1) busy_ok = 1'b0;
      repeat (64) @(negedge clk);
    end
`ifdef UART_TX_PARITY_EN
    par = ifa.tx;
    if (ifa.tx_busy !== 1'b1) busy_ok = 1'b0;
    repeat (64) @(negedge clk);
`endif
    stop_bit = ifa.tx;
    if (ifa.tx_busy !== 1'b1) busy_ok = 1'b0;
    n = 0;
    while (ifa.tx_done_tick !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    check_eq("rx_done_seen", ifa.tx_done_tick, 1'b1);
    flen = cyc - t0;
  endtask

  task automatic wait_b(input logic lvl, input int limit, input string tag, output int t);
    int n;
    n = 0;
    while (ifb.tx !== lvl && n < limit) begin @(negedge clk); n++; end
    check_eq(tag, ifb.tx, lvl);
    t = cyc;
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       p, s, bz;
    int         fl, t1, t2, t3, n;

    ifa.tx_start = 1'b0; ifa.din = '0;
    ifb.tx_start = 1'b0; ifb.din = '0;
`ifdef UART_TX_PARITY_EN
    ifa.parity_odd = 1'b0;
    ifb.parity_odd = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx", ifa.tx, 1'b1);
    check_eq("rst_busy", ifa.tx_busy, 1'b0);
    check_eq("rst_done", ifa.tx_done_tick, 1'b0);
    @(negedge clk) reset_n = 1'b1;
    repeat (5) @(posedge clk);

    // basic frame 0x55 with edge timing
    edge_t.delete(); done_t.delete();
    send_a(8'h55);
    check_eq("latency_tx_low", ifa.tx, 1'b0);
    check_eq("latency_busy", ifa.tx_busy, 1'b1);
    recv_a(d, p, s, bz, fl);
    check_eq("b55_data", d, 8'h55);
    check_eq("b55_stop", s, 1'b1);
    check_eq("b55_busy_held", bz, 1'b1);
    check_eq("b55_frame_len_ok", (fl >= FLEN_MIN && fl <= FLEN_MAX), 1'b1);
`ifdef UART_TX_PARITY_EN
    check_eq("b55_parity", p, 1'b0);
`endif
    repeat (20) @(negedge clk);
    check_eq("b55_done_count", done_t.size(), 1);
    check_eq("b55_edge_count", edge_t.size(), 10);
    if (edge_t.size() == 10 && done_t.size() == 1) begin
      check_eq("b55_start_len_ok", (edge_t[1] - edge_t[0] >= 60 && edge_t[1] - edge_t[0] <= 64), 1'b1);
      for (int k = 1; k < 8; k++) check_eq($sformatf("b55_bit%0d_len", k - 1), edge_t[k + 1] - edge_t[k], 64);
      check_eq("b55_bit7_len", edge_t[9] - edge_t[8], 64 * (1 + PBITS));
      check_eq("b55_stop_to_done", done_t[0] - edge_t[9], 64);
    end

    // start request while busy is dropped
    done_t.delete();
    send_a(8'hA3);
    fork
      recv_a(d, p, s, bz, fl);
      begin
        repeat (230) @(posedge clk);
        #1; ifa.din = 8'hFF; ifa.tx_start = 1'b1;
        @(posedge clk);
        #1; ifa.tx_start = 1'b0;
      end
    join
    check_eq("ign_data", d, 8'hA3);
    repeat (300) @(negedge clk);
    check_eq("ign_done_count", done_t.size(), 1);
    check_eq("ign_tx_idle", ifa.tx, 1'b1);
    check_eq("ign_busy_idle", ifa.tx_busy, 1'b0);

    // back-to-back frames
    send_a(8'hF0);
    recv_a(d, p, s, bz, fl);
    check_eq("b2b_first", d, 8'hF0);
    send_a(8'h0F);
    check_eq("b2b_start_next_clk", ifa.tx, 1'b0);
    recv_a(d, p, s, bz, fl);
    check_eq("b2b_second", d, 8'h0F);

    // reset mid-frame during data bit 3
    repeat (10) @(posedge clk);
    done_t.delete();
    send_a(8'h00);
    repeat (285) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("rstmid_tx_before", ifa.tx, 1'b0);
    reset_n = 1'b0;
    #1;
    check_eq("rstmid_tx_async", ifa.tx, 1'b1);
    check_eq("rstmid_busy_async", ifa.tx_busy, 1'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("rstmid_no_done", done_t.size(), 0);
    send_a(8'h81);
    recv_a(d, p, s, bz, fl);
    check_eq("rstmid_next_frame", d, 8'h81);

`ifdef UART_TX_PARITY_EN
    ifa.parity_odd = 1'b0;
    send_a(8'h07);
    recv_a(d, p, s, bz, fl);
    check_eq("par_even_data", d, 8'h07);
    check_eq("par_even_bit", p, 1'b1);
    check_eq("par_even_len_ok", (fl >= FLEN_MIN && fl <= FLEN_MAX), 1'b1);
    ifa.parity_odd = 1'b1;
    send_a(8'h07);
    ifa.parity_odd = 1'b0;
    recv_a(d, p, s, bz, fl);
    check_eq("par_odd_data", d, 8'h07);
    check_eq("par_odd_bit", p, 1'b0);
    check_eq("par_odd_len_ok", (fl >= FLEN_MIN && fl <= FLEN_MAX), 1'b1);
`endif

    // real-rate tick, two stop bits
    send_b(8'h01);
    check_eq("b_start_low", ifb.tx, 1'b0);
    wait_b(1'b1, 8000, "b_bit0_rise", t1);
    wait_b(1'b0, 8000, "b_bit1_fall", t2);
    check_eq("b_bit0_len_ok", (t2 - t1 >= 5216 - 326 && t2 - t1 <= 5216 + 326), 1'b1);
    wait_b(1'b1, 45000, "b_stop_rise", t3);
    n = 0;
    while (ifb.tx_done_tick !== 1'b1 && n < 25000) begin @(negedge clk); n++; end
    check_eq("b_done_seen", ifb.tx_done_tick, 1'b1);
    check_eq("b_stop_to_done", cyc - t3, STOP_B_EXP);
    @(negedge clk);
    check_eq("b_done_width", ifb.tx_done_tick, 1'b0);
    check_eq("b_busy_end", ifb.tx_busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
